row_access_seq: RTL and testbench

- Row-access sequencer that drives the real-valued row-select address bus into the SRAM row decoder.
- Accepts a logic row request over a valid/ready handshake and encodes the row index into real voltage levels on row_sel.
- Holds the address for a programmable setup and active window, then samples the decoder's real-valued wordline feedback.
- Encodes that feedback back to a row index and reports completion plus a mismatch flag.

---
 rtl/row_access_seq_pkg.sv | 24 ++
 rtl/row_access_seq_if.sv | 27 ++
 rtl/row_access_seq_fb_encoder.sv | 32 +++
 rtl/row_access_seq.sv | 143 ++++++++++++++
 tb/tb_row_access_seq.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/row_access_seq_pkg.sv
// rtl/row_access_seq_pkg.sv - shared levels, state enum and real/logic conversion helpers
package row_seq_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_CHECK,
        ST_RELEASE
    } state_t;

    function automatic real logic_to_real(input logic b);
        return b ? VDD : VSS;
    endfunction

    function automatic logic real_to_logic(input real v);
        return (v >= VTH);
    endfunction

endpackage

// File: rtl/row_access_seq_if.sv
// rtl/row_access_seq_if.sv - request/done handshake and real-valued decoder bus
interface row_access_seq_if #(
    parameter int ROWS = 16
);
    localparam int AW = $clog2(ROWS);

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_row;
    real           row_sel [0:AW-1];
    real           row_fb  [0:ROWS-1];
    logic          done_valid;
    logic [AW-1:0] done_row;
    logic          done_err;
    logic          err_range;

    modport master (
        input  req_valid, req_row, row_fb,
        output req_ready, row_sel, done_valid, done_row, done_err, err_range
    );

    modport slave (
        output req_valid, req_row, row_fb,
        input  req_ready, row_sel, done_valid, done_row, done_err, err_range
    );

endinterface

// File: rtl/row_access_seq_fb_encoder.sv
// rtl/row_access_seq_fb_encoder.sv - thresholds wordline feedback into lowest index, onehot and none flags
module row_fb_encoder
    import row_seq_pkg::*;
#(
    parameter  int ROWS = 16,
    localparam int AW   = $clog2(ROWS)
) (
    input  real           i_fb [0:ROWS-1],
    output logic [AW-1:0] o_row,
    output logic          o_onehot,
    output logic          o_none
);

    logic [ROWS-1:0] w_bits;

    always_comb begin
        w_bits = '0;
        o_row  = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_bits[i] = real_to_logic(i_fb[i]);
        end
        // Scan downward so the lowest asserted wordline wins.
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (w_bits[i]) begin
                o_row = AW'(i);
            end
        end
        o_onehot = ($countones(w_bits) == 1);
        o_none   = (w_bits == '0);
    end

endmodule

// File: rtl/row_access_seq.sv
// rtl/row_access_seq.sv - row-access sequencer; ROW_SEQ_FB_CHECK_EN enables wordline feedback checking
module row_access_seq
    import row_seq_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    row_access_seq_if.master  bus
);

    localparam int AW   = $clog2(ROWS);
    localparam int CMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [AW:0]   MAX_ROW    = (AW+1)'(ROWS - 2);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_row;
    logic [AW-1:0] r_code;
    logic          r_done_valid;
    logic [AW-1:0] r_done_row;
    logic          r_done_err;
    logic          r_err_range;

    logic          w_hs;
    logic          w_in_range;
    logic          w_setup_last;
    logic          w_hold_last;
    logic          w_drive;
    logic [AW-1:0] w_fb_row;
    logic          w_fb_err;

    assign w_hs         = (r_state == ST_IDLE) && bus.req_valid;
    assign w_in_range   = ({1'b0, bus.req_row} <= MAX_ROW);
    assign w_setup_last = (r_cnt == SETUP_LAST);
    assign w_hold_last  = (r_cnt == HOLD_LAST);
    assign w_drive      = (r_state == ST_SETUP) || (r_state == ST_ACTIVE) || (r_state == ST_CHECK);

`ifdef ROW_SEQ_FB_CHECK_EN
    logic w_onehot;
    logic w_none;

    row_fb_encoder #(.ROWS(ROWS)) u_fb_enc (
        .i_fb     (bus.row_fb),
        .o_row    (w_fb_row),
        .o_onehot (w_onehot),
        .o_none   (w_none)
    );

    assign w_fb_err = w_none || !(w_onehot && (w_fb_row == r_row));
`else
    assign w_fb_row = r_row;
    assign w_fb_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_hs) w_next = w_in_range ? ST_SETUP : ST_CHECK;
            ST_SETUP:   if (w_setup_last) w_next = ST_ACTIVE;
            ST_ACTIVE:  if (w_hold_last) w_next = ST_CHECK;
            ST_CHECK:   w_next = ST_RELEASE;
            ST_RELEASE: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (r_state == ST_IDLE) && !rst;
        bus.done_valid = r_done_valid;
        bus.done_row   = r_done_row;
        bus.done_err   = r_done_err;
        bus.err_range  = r_err_range;
        for (int i = 0; i < AW; i++) begin
            bus.row_sel[i] = w_drive ? logic_to_real(r_code[i]) : VSS;
        end
    end

    // Dwell counter restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == ST_SETUP) || (r_state == ST_ACTIVE)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // An out-of-range request leaves the code at zero so row_sel never leaves VSS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row  <= '0;
            r_code <= '0;
        end else if (w_hs) begin
            if (w_in_range) begin
                r_row  <= bus.req_row;
                r_code <= bus.req_row + AW'(1);
            end else begin
                r_row  <= '0;
                r_code <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_valid <= 1'b0;
            r_done_row   <= '0;
            r_done_err   <= 1'b0;
            r_err_range  <= 1'b0;
        end else begin
            r_done_valid <= 1'b0;
            r_done_row   <= '0;
            r_done_err   <= 1'b0;
            r_err_range  <= 1'b0;
            if (w_hs && !w_in_range) begin
                r_done_valid <= 1'b1;
                r_err_range  <= 1'b1;
            end else if ((r_state == ST_ACTIVE) && w_hold_last) begin
                r_done_valid <= 1'b1;
                r_done_row   <= w_fb_row;
                r_done_err   <= w_fb_err;
            end
        end
    end

endmodule

// File: tb/tb_row_access_seq.sv
// tb/tb_row_access_seq.sv - randomized self-checking bench for row_access_seq with decoder model
module tb_row_access_seq;

    localparam int ROWS = 16;
    localparam int AW   = $clog2(ROWS);
    localparam int S    = 2;
    localparam int H    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    bit   fb_loop = 1'b1;
    real  fb_manual [0:ROWS-1];

    row_access_seq_if #(.ROWS(ROWS)) bus ();

    row_access_seq #(
        .ROWS      (ROWS),
        .SETUP_CYC (S),
        .HOLD_CYC  (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal decoder: code c lights wordline c-1, code 0 lights nothing.
    logic [AW-1:0] dec_code;
    for (genvar g = 0; g < AW; g++) begin : g_dec
        assign dec_code[g] = (bus.row_sel[g] >= 0.75);
    end
    for (genvar g = 0; g < ROWS; g++) begin : g_fb
        assign bus.row_fb[g] = fb_loop ? ((int'(dec_code) == g + 1) ? 1.5 : 0.0) : fb_manual[g];
    end

    function automatic int sel_code();
        int c = 0;
        for (int i = 0; i < AW; i++) begin
            if (bus.row_sel[i] == 1.5) c = c | (1 << i);
            else if (bus.row_sel[i] != 0.0) return -1;
        end
        return c;
    endfunction

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!bus.req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = bus.req_ready;
    endtask

    task automatic run_req(input int row, input string name);
        int exp_lat, exp_code, exp_row, code, want, cnt, low;
        bit exp_err, exp_rng, ok;
        exp_rng  = (row > ROWS - 2);
        exp_code = exp_rng ? 0 : row + 1;
        exp_lat  = exp_rng ? 1 : 1 + S + H;
        exp_row  = 0;
        exp_err  = 1'b0;
        if (!exp_rng) begin
`ifdef ROW_SEQ_FB_CHECK_EN
            if (fb_loop) begin
                exp_row = row;
            end else begin
                cnt = 0;
                low = -1;
                for (int i = 0; i < ROWS; i++) begin
                    if (fb_manual[i] >= 0.8) begin
                        cnt++;
                        if (low < 0) low = i;
                    end
                end
                exp_row = (low < 0) ? 0 : low;
                exp_err = !(cnt == 1 && low == row);
            end
`else
            exp_row = row;
`endif
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_row   = AW'(row);
        wait_ready(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s handshake: req_ready got 0 want 1 within budget", name);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= exp_lat + 1; k++) begin
            @(negedge clk);
            code = sel_code();
            want = (k <= exp_lat) ? exp_code : 0;
            tests_run++;
            if (code !== want) begin
                tests_failed++;
                $display("FAIL %s row_sel t+%0d: got code %0d want %0d", name, k, code, want);
            end
            if (k == 1) begin
                tests_run++;
                if (bus.req_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s req_ready t+1: got %b want 0", name, bus.req_ready);
                end
            end
            tests_run++;
            if (bus.done_valid !== (k == exp_lat)) begin
                tests_failed++;
                $display("FAIL %s done_valid t+%0d: got %b want %b", name, k, bus.done_valid, (k == exp_lat));
            end
            if (k == exp_lat) begin
                tests_run++;
                if (bus.done_row !== AW'(exp_row) || bus.done_err !== exp_err || bus.err_range !== exp_rng) begin
                    tests_failed++;
                    $display("FAIL %s done fields: got row %0d err %b rng %b want row %0d err %b rng %b",
                             name, bus.done_row, bus.done_err, bus.err_range, exp_row, exp_err, exp_rng);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_row   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (sel_code() !== 0 || bus.done_valid !== 1'b0 || bus.done_row !== '0 ||
            bus.done_err !== 1'b0 || bus.err_range !== 1'b0 || bus.req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset state: got code %0d dv %b row %0d err %b rng %b rdy %b want all 0",
                     sel_code(), bus.done_valid, bus.done_row, bus.done_err, bus.err_range, bus.req_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset release req_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_loop_row5();
        fb_loop = 1'b1;
        run_req(5, "loop_row5");
    endtask

    task automatic test_out_of_range();
        fb_loop = 1'b1;
        run_req(ROWS - 1, "out_of_range");
    endtask

    task automatic test_multi_fb();
        fb_loop = 1'b0;
        for (int i = 0; i < ROWS; i++) fb_manual[i] = 0.0;
        fb_manual[3] = 1.5;
        fb_manual[4] = 1.5;
        run_req(3, "multi_fb");
    endtask

    task automatic test_threshold();
        fb_loop = 1'b0;
        for (int i = 0; i < ROWS; i++) fb_manual[i] = 0.0;
        fb_manual[2] = 0.79;
        run_req(2, "thresh_0p79");
        fb_manual[2] = 0.8;
        run_req(2, "thresh_0p80");
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        fb_loop = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_row   = AW'(9);
        wait_ready(ok);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (S + 2) @(negedge clk);
        tests_run++;
        if (!ok || sel_code() !== 10) begin
            tests_failed++;
            $display("FAIL rst_mid active row_sel: got code %0d want 10 (hs ok %b)", sel_code(), ok);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (sel_code() !== 0 || bus.done_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid async: got code %0d dv %b rdy %b want 0 0 0",
                     sel_code(), bus.done_valid, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid dropped: got done_valid 1 want none");
        end
        run_req(0, "after_rst_row0");
    endtask

    task automatic test_back_to_back();
        int hs[$];
        int dn[$];
        int dr[$];
        int de[$];
        int n = 0;
        fb_loop = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_row   = AW'(1);
        while (dn.size() < 2 && n < 60) begin
            if (bus.req_valid && bus.req_ready) hs.push_back(cyc);
            if (bus.done_valid) begin
                dn.push_back(cyc);
                dr.push_back(int'(bus.done_row));
                de.push_back(int'(bus.done_err));
            end
            @(negedge clk);
            n++;
            if (hs.size() == 1) bus.req_row = AW'(7);
            if (hs.size() == 2) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        tests_run++;
        if (hs.size() != 2 || dn.size() != 2) begin
            tests_failed++;
            $display("FAIL b2b counts: got %0d handshakes %0d dones want 2 2", hs.size(), dn.size());
            return;
        end
        tests_run++;
        if (hs[1] - hs[0] !== S + H + 3) begin
            tests_failed++;
            $display("FAIL b2b handshake spacing: got %0d want %0d", hs[1] - hs[0], S + H + 3);
        end
        tests_run++;
        if (dn[1] - dn[0] !== S + H + 3 || dn[0] - hs[0] !== 1 + S + H) begin
            tests_failed++;
            $display("FAIL b2b done timing: got spacing %0d latency %0d want %0d %0d",
                     dn[1] - dn[0], dn[0] - hs[0], S + H + 3, 1 + S + H);
        end
        tests_run++;
        if (dr[0] !== 1 || dr[1] !== 7 || de[0] !== 0 || de[1] !== 0) begin
            tests_failed++;
            $display("FAIL b2b done fields: got rows %0d %0d errs %0d %0d want 1 7 0 0",
                     dr[0], dr[1], de[0], de[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            int row;
            row = $urandom_range(0, ROWS - 1);
            if ($urandom_range(0, 1) == 1) begin
                fb_loop = 1'b1;
            end else begin
                fb_loop = 1'b0;
                for (int i = 0; i < ROWS; i++) begin
                    case ($urandom_range(0, 7))
                        0:       fb_manual[i] = 1.5;
                        1:       fb_manual[i] = 0.79;
                        2:       fb_manual[i] = 0.8;
                        default: fb_manual[i] = 0.0;
                    endcase
                end
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < ROWS; i++) fb_manual[i] = 0.0;
                    fb_manual[row] = 1.5;
                end
            end
            run_req(row, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++) fb_manual[i] = 0.0;
        bus.req_valid = 1'b0;
        bus.req_row   = '0;
        test_reset();
        test_loop_row5();
        test_out_of_range();
        test_multi_fb();
        test_threshold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
